// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: divides sys_clk to the pixel rate and produces
// the pixel coordinate, video_on, sync pulses and pixel/line/frame strobes.
module vga_sync_gen #(
    parameter int CLK_DIV      = 4,
    parameter int H_DISPLAY    = 640,
    parameter int H_FRONT      = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BACK       = 48,
    parameter int V_DISPLAY    = 480,
    parameter int V_FRONT      = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BACK       = 33,
    parameter bit SYNC_ACTIVE  = 1'b0,
    parameter int SCREEN_WIDTH = 10
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst,
    output logic [SCREEN_WIDTH-1:0] x,
    output logic [SCREEN_WIDTH-1:0] y,
    output logic                    video_on,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    p_tick,
    output logic                    line_start,
    output logic                    frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [SCREEN_WIDTH-1:0] H_LAST   = SCREEN_WIDTH'(H_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0] V_LAST   = SCREEN_WIDTH'(V_TOTAL - 1);
    localparam logic [SCREEN_WIDTH-1:0] H_VIS    = SCREEN_WIDTH'(H_DISPLAY);
    localparam logic [SCREEN_WIDTH-1:0] V_VIS    = SCREEN_WIDTH'(V_DISPLAY);
    localparam logic [SCREEN_WIDTH-1:0] HS_LO    = SCREEN_WIDTH'(H_DISPLAY + H_FRONT);
    localparam logic [SCREEN_WIDTH-1:0] HS_HI    = SCREEN_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [SCREEN_WIDTH-1:0] VS_LO    = SCREEN_WIDTH'(V_DISPLAY + V_FRONT);
    localparam logic [SCREEN_WIDTH-1:0] VS_HI    = SCREEN_WIDTH'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0]        div_cnt;
    logic [DIV_W-1:0]        div_nxt;
    logic [SCREEN_WIDTH-1:0] x_nxt;
    logic [SCREEN_WIDTH-1:0] y_nxt;
    logic                    adv;

    function automatic logic in_window(input logic [SCREEN_WIDTH-1:0] v,
                                       input logic [SCREEN_WIDTH-1:0] lo,
                                       input logic [SCREEN_WIDTH-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    function automatic logic sync_level(input logic active);
        return active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    endfunction

    assign adv = (div_cnt == DIV_LAST);

    always_comb begin
        div_nxt = div_cnt + 1'b1;
        x_nxt   = x;
        y_nxt   = y;
        if (adv) begin
            div_nxt = '0;
            x_nxt   = (x == H_LAST) ? '0 : x + 1'b1;
            if (x == H_LAST) begin
                y_nxt = (y == V_LAST) ? '0 : y + 1'b1;
            end
        end
    end

    // Every output is decoded from the next counter values so it lines up with x/y.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_cnt     <= '0;
            x           <= H_LAST;
            y           <= V_LAST;
            video_on    <= 1'b0;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            p_tick      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= div_nxt;
            x           <= x_nxt;
            y           <= y_nxt;
            video_on    <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
            hsync       <= sync_level(in_window(x_nxt, HS_LO, HS_HI));
            vsync       <= sync_level(in_window(y_nxt, VS_LO, VS_HI));
            p_tick      <= adv;
            line_start  <= adv && (x_nxt == '0);
            frame_start <= adv && (x_nxt == '0) && (y_nxt == '0);
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: two reduced-raster builds (CLK_DIV=3 active-low sync,
// CLK_DIV=1 active-high sync) against a pixel-index model, plus frame statistics.
module tb_vga_sync_gen;

    localparam int HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int VD = 5, VF = 1, VS = 2, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int SW = 5;
    localparam int DIV_A = 3;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic [SW-1:0] xa, ya, xb, yb;
    logic          von_a, hs_a, vs_a, pt_a, ls_a, fs_a;
    logic          von_b, hs_b, vs_b, pt_b, ls_b, fs_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int na    = 0;

    always #5 sys_clk = ~sys_clk;

    vga_sync_gen #(
        .CLK_DIV(DIV_A), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(1'b0), .SCREEN_WIDTH(SW)
    ) u_dut_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .x(xa), .y(ya), .video_on(von_a),
        .hsync(hs_a), .vsync(vs_a), .p_tick(pt_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE(1'b1), .SCREEN_WIDTH(SW)
    ) u_dut_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .x(xb), .y(yb), .video_on(von_b),
        .hsync(hs_b), .vsync(vs_b), .p_tick(pt_b), .line_start(ls_b), .frame_start(fs_b)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: n edges since reset release -> pixel index n/div, raster scanned row-major.
    task automatic check_model(input string pfx, input int n, input int div, input bit sa,
                               input int gx, input int gy, input int gv, input int ghs,
                               input int gvs, input int gpt, input int gls, input int gfs);
        int p, l, ex, ey, ev, ehs, evs, ept, els, efs;
        p = n / div;
        if (p == 0) begin
            ex = HT - 1; ey = VT - 1; ev = 0; ehs = ~sa; evs = ~sa;
            ept = 0; els = 0; efs = 0;
        end else begin
            l   = (p - 1) % (HT * VT);
            ex  = l % HT;
            ey  = l / HT;
            ev  = (ex < HD && ey < VD) ? 1 : 0;
            ehs = (ex >= HD + HF && ex < HD + HF + HS) ? sa : ~sa;
            evs = (ey >= VD + VF && ey < VD + VF + VS) ? sa : ~sa;
            ept = (n % div == 0) ? 1 : 0;
            els = (ept == 1 && ex == 0) ? 1 : 0;
            efs = (els == 1 && ey == 0) ? 1 : 0;
        end
        check({pfx, ".x"}, gx, ex);
        check({pfx, ".y"}, gy, ey);
        check({pfx, ".video_on"}, gv, ev);
        check({pfx, ".hsync"}, ghs, ehs & 1);
        check({pfx, ".vsync"}, gvs, evs & 1);
        check({pfx, ".p_tick"}, gpt, ept);
        check({pfx, ".line_start"}, gls, els);
        check({pfx, ".frame_start"}, gfs, efs);
    endtask

    task automatic step();
        @(posedge sys_clk);
        na = sys_rst ? 0 : na + 1;
        cyc++;
        #1;
        check_model("a", na, DIV_A, 1'b0, xa, ya, von_a, hs_a, vs_a, pt_a, ls_a, fs_a);
        check_model("b", na, 1,     1'b1, xb, yb, von_b, hs_b, vs_b, pt_b, ls_b, fs_b);
    endtask

    initial begin
        int first_a, second_a, first_b, second_b;
        int c, von_cnt, hs_cnt, vs_cnt, ls_cnt, pt_b_cnt;

        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;

        // Random run lengths with resets landing anywhere in the frame.
        for (int it = 0; it < 20; it++) begin
            int run_len;
            int rst_len;
            run_len = $urandom_range(1, 3 * HT * VT * DIV_A / 2);
            rst_len = $urandom_range(1, 3);
            for (int i = 0; i < run_len; i++) step();
            sys_rst = 1'b1;
            for (int i = 0; i < rst_len; i++) step();
            sys_rst = 1'b0;
        end

        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        first_a = -1; second_a = -1; first_b = -1; second_b = -1;
        von_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0; pt_b_cnt = 0;
        c = 0;
        while (c < 3 * HT * VT * DIV_A && second_a < 0) begin
            step();
            c++;
            if (fs_a) begin
                if (first_a < 0) first_a = c;
                else second_a = c;
            end
            if (fs_b) begin
                if (first_b < 0) first_b = c;
                else if (second_b < 0) second_b = c;
            end
            if (first_a >= 0 && second_a < 0) begin
                von_cnt += von_a;
                hs_cnt  += (hs_a == 1'b0);
                vs_cnt  += (vs_a == 1'b0);
                ls_cnt  += ls_a;
            end
            if (first_b >= 0 && second_b < 0) pt_b_cnt += pt_b;
        end
        check("first_frame_start_a", first_a, DIV_A);
        check("frame_period_a", second_a - first_a, HT * VT * DIV_A);
        check("video_on_cycles", von_cnt, HD * VD * DIV_A);
        check("hsync_low_cycles", hs_cnt, HS * DIV_A * VT);
        check("vsync_low_cycles", vs_cnt, VS * HT * DIV_A);
        check("lines_per_frame", ls_cnt, VT);
        check("first_frame_start_b", first_b, 1);
        check("frame_period_b", second_b - first_b, HT * VT);
        check("p_tick_cycles_b", pt_b_cnt, HT * VT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
